led_decrypt_core: RTL and testbench

//  LED-64 block decryptor: the inverse of the encryption path in tt_um_led_cipher.

---
 rtl/led_pkg.sv | 52 +++++
 rtl/led_decrypt_core_if.sv | 21 ++
 rtl/led_inv_round.sv | 41 ++++
 rtl/led_decrypt_core.sv | 109 ++++++++++
 tb/tb_led_decrypt_core.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// LED-64 constants, nibble matrices and GF(2^4) multiply shared by the
// encrypt and decrypt cores.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  localparam logic [5:0] RC [32] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B,
    6'h37, 6'h2F, 6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E,
    6'h1D, 6'h3A, 6'h35, 6'h2B, 6'h16, 6'h2C, 6'h18, 6'h30,
    6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E, 6'h1C, 6'h38
  };

  // Inverse of the serial MixColumns matrix (A^4)^-1.
  localparam logic [3:0] MINV [4][4] = '{
    '{4'hC, 4'hC, 4'hD, 4'h4},
    '{4'h3, 4'h8, 4'h4, 4'h5},
    '{4'h7, 4'h6, 4'h2, 4'hE},
    '{4'hD, 4'h9, 4'h9, 4'hD}
  };

  // Column-0 constants fold in the 64-bit key size (0x40).
  localparam logic [3:0] AC_COL0 [4] = '{4'h4, 4'h5, 4'h2, 4'h3};

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

endpackage

// File: rtl/led_decrypt_core_if.sv
// Byte-serial load/stream bundle between the decryptor and its host.
interface led_decrypt_core_if;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/led_inv_round.sv
// One LED inverse round without the key XOR:
// invMixColumnsSerial, invShiftRows, invSubCells, AddConstants(rc).
module led_inv_round
  import led_pkg::*;
(
  input  logic [63:0] s_in,
  input  logic [5:0]  rc,
  output logic [63:0] s_out
);

  logic [3:0] n_in [16];
  logic [3:0] n_mc [16];
  logic [3:0] n_sr [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_nib
    localparam int R = gi / 4;
    localparam int C = gi % 4;
    logic [3:0] ac;

    assign n_in[gi] = s_in[63-4*gi -: 4];
    assign n_mc[gi] = gf16_mul(MINV[R][0], n_in[C])
                    ^ gf16_mul(MINV[R][1], n_in[4+C])
                    ^ gf16_mul(MINV[R][2], n_in[8+C])
                    ^ gf16_mul(MINV[R][3], n_in[12+C]);
    // Row r rotates right by r nibbles.
    assign n_sr[gi] = n_mc[4*R + ((C - R + 4) % 4)];

    if (C == 0) begin : g_ac_col0
      assign ac = AC_COL0[R];
    end else if (C == 1 && (R % 2) == 0) begin : g_ac_hi
      assign ac = {1'b0, rc[5:3]};
    end else if (C == 1) begin : g_ac_lo
      assign ac = {1'b0, rc[2:0]};
    end else begin : g_ac_none
      assign ac = 4'h0;
    end

    assign s_out[63-4*gi -: 4] = INV_SBOX[n_sr[gi]] ^ ac;
  end

endmodule

// File: rtl/led_decrypt_core.sv
// LED-64 block decryptor: byte-serial key and ciphertext in, one inverse
// round per cycle, byte-serial plaintext out.
module led_decrypt_core
  import led_pkg::*;
#(
  parameter int NROUNDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  led_decrypt_core_if.slave bus
);

  localparam int RW = $clog2(NROUNDS);

  state_t        state_q;
  logic [63:0]   k_q;
  logic [63:0]   s_q;
  logic [3:0]    byte_cnt_q;
  logic [2:0]    out_cnt_q;
  logic [RW-1:0] rnd_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic [63:0]   s_inv;
  logic [63:0]   s_round_d;

  led_inv_round u_inv_round (
    .s_in  (s_q),
    .rc    (RC[rnd_q]),
    .s_out (s_inv)
  );

  // Key is re-added after every fourth inverse round.
  assign s_round_d = s_inv ^ ((rnd_q[1:0] == 2'b00) ? k_q : 64'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      s_q         <= '0;
      byte_cnt_q  <= '0;
      out_cnt_q   <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.clear) begin
      state_q     <= IDLE;
      k_q         <= '0;
      s_q         <= '0;
      byte_cnt_q  <= '0;
      out_cnt_q   <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= LOAD;
          in_ready_q <= 1'b1;
        end
        LOAD: begin
          if (bus.in_valid && in_ready_q) begin
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (!byte_cnt_q[3]) begin
              k_q <= {k_q[55:0], bus.in_data};
            end else if (byte_cnt_q == 4'hF) begin
              s_q        <= {s_q[55:0], bus.in_data} ^ k_q;
              rnd_q      <= RW'(NROUNDS - 1);
              state_q    <= ROUND;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              s_q <= {s_q[55:0], bus.in_data};
            end
          end
        end
        ROUND: begin
          s_q <= s_round_d;
          if (rnd_q == '0) state_q <= OUT;
          else             rnd_q   <= rnd_q - RW'(1);
        end
        OUT: begin
          // First OUT cycle only raises out_valid; bytes move after that.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            s_q       <= {s_q[55:0], 8'h00};
            out_cnt_q <= out_cnt_q + 3'd1;
            if (out_cnt_q == 3'd7) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              k_q         <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = s_q[63:56];
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_led_decrypt_core.sv
// Bench for led_decrypt_core: forward LED-64 reference model produces the
// ciphertexts; a negedge monitor checks every accepted plaintext byte.
module tb_led_decrypt_core;

  logic clk;
  logic rst_n;
  led_decrypt_core_if bus();

  led_decrypt_core #(.NROUNDS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_tests    = 0;
  int         n_fail     = 0;
  int         n_accepted = 0;
  logic [7:0] exp_q [$];
  bit         bp_mode    = 1'b0;
  bit         stall_seen = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic [7:0] want;

  localparam logic [63:0] K2 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h39C2401003A0C798;
  localparam logic [63:0] C2 = 64'hA003551E3893FC58;

  localparam logic [3:0] SBOX_TB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };
  localparam logic [3:0] MIX_TB [4][4] = '{
    '{4'h4, 4'h1, 4'h2, 4'h2},
    '{4'h8, 4'h6, 4'h5, 4'h6},
    '{4'hB, 4'hE, 4'hA, 4'h9},
    '{4'h2, 4'h2, 4'hF, 4'hB}
  };

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] prod;
    prod = 8'h00;
    for (int i = 0; i < 4; i++) if (b[i]) prod = prod ^ (8'(a) << i);
    for (int i = 7; i >= 4; i--) if (prod[i]) prod = prod ^ (8'h13 << (i - 4));
    return prod[3:0];
  endfunction

  // Forward LED-64 encryption: AddConstants, SubCells, ShiftRows, MixColumns.
  function automatic logic [63:0] led_enc(input logic [63:0] k, input logic [63:0] p);
    logic [3:0]  st  [4][4];
    logic [3:0]  tmp [4][4];
    logic [3:0]  acc;
    logic [63:0] s;
    logic [5:0]  rc;
    s  = p ^ k;
    rc = 6'd0;
    for (int step = 0; step < 8; step++) begin
      for (int j = 0; j < 4; j++) begin
        rc = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) st[r][c] = s[63-4*(4*r+c) -: 4];
        st[0][0] = st[0][0] ^ 4'h4;
        st[1][0] = st[1][0] ^ 4'h5;
        st[2][0] = st[2][0] ^ 4'h2;
        st[3][0] = st[3][0] ^ 4'h3;
        st[0][1] = st[0][1] ^ {1'b0, rc[5:3]};
        st[2][1] = st[2][1] ^ {1'b0, rc[5:3]};
        st[1][1] = st[1][1] ^ {1'b0, rc[2:0]};
        st[3][1] = st[3][1] ^ {1'b0, rc[2:0]};
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) st[r][c] = SBOX_TB[st[r][c]];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) tmp[r][c] = st[r][(c + r) % 4];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            acc = 4'h0;
            for (int q = 0; q < 4; q++) acc = acc ^ gmul(MIX_TB[r][q], tmp[q][c]);
            st[r][c] = acc;
          end
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) s[63-4*(4*r+c) -: 4] = st[r][c];
      end
      s = s ^ k;
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Output monitor: every accepted byte against the expected queue, plus
  // out_data stability while stalled.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (stall_seen) begin
        n_tests++;
        if (bus.out_data !== stall_data) begin
          n_fail++;
          $display("FAIL stall_stable: out_data %h, required %h", bus.out_data, stall_data);
        end
      end
      if (bus.out_ready && !bus.clear) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got %h, required no output", bus.out_data);
        end else begin
          want = exp_q.pop_front();
          n_accepted++;
          if (bus.out_data !== want) begin
            n_fail++;
            $display("FAIL out_byte: got %h, required %h", bus.out_data, want);
          end
        end
      end
      stall_seen = !bus.out_ready && !bus.clear;
      stall_data = bus.out_data;
    end else begin
      stall_seen = 1'b0;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input logic [63:0] k, input logic [63:0] c,
                            input int gap_pct, input bit clear_last);
    logic [127:0] data;
    int guard;
    data = {k, c};
    for (int i = 0; i < 16; i++) begin
      while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = data[127-8*i -: 8];
      if (i == 15 && clear_last) bus.clear = 1'b1;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
        tick();
        guard++;
      end
      if (guard >= 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL load_timeout: in_ready %0b at byte %0d, required 1", bus.in_ready, i);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic push_expected(input logic [63:0] p);
    for (int i = 0; i < 8; i++) exp_q.push_back(p[63-8*i -: 8]);
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 400) begin
      tick();
      guard++;
    end
    n_tests++;
    if (guard >= 400) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d bytes pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic run_cp(input string name, input logic [63:0] k, input logic [63:0] c,
                        input logic [63:0] p, input int gap_pct);
    n_accepted = 0;
    load_block(k, c, gap_pct, 1'b0);
    push_expected(p);
    wait_done(name);
    check({name, "_count"}, 64'(n_accepted), 64'd8);
    $display("[TB] %s K=%h C=%h P=%h", name, k, c, p);
  endtask

  initial begin
    int lat;
    logic [63:0] rk;
    logic [63:0] rp;

    rst_n        = 1'b0;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    rst_n = 1'b1;

    // Pin the reference model to the published LED-64 vectors.
    check("model_vec1", led_enc(64'h0, 64'h0), C1);
    check("model_vec2", led_enc(K2, K2), C2);

    // Vector 1 with latency measurement.
    n_accepted = 0;
    load_block(64'h0, C1, 0, 1'b0);
    push_expected(64'h0);
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd33);
    check("busy_in_out", 64'(bus.busy), 64'd1);
    wait_done("vec1");
    check("vec1_count", 64'(n_accepted), 64'd8);
    $display("[TB] vec1 K=%h C=%h P=%h latency=%0d", 64'h0, C1, 64'h0, lat);

    run_cp("vec2", K2, C2, K2, 0);

    // Backpressure and input gaps.
    bp_mode = 1'b1;
    run_cp("vec2_bp_gaps", K2, C2, K2, 40);

    for (int i = 0; i < 40; i++) begin
      rk = {$urandom, $urandom};
      rp = {$urandom, $urandom};
      run_cp("rand", rk, led_enc(rk, rp), rp, (i % 3 == 0) ? 25 : 0);
    end
    bp_mode = 1'b0;
    tick();

    // Abort on the byte-15 edge.
    load_block(K2, C2, 0, 1'b1);
    check("clr15_busy",      64'(bus.busy),      64'd0);
    check("clr15_in_ready",  64'(bus.in_ready),  64'd0);
    check("clr15_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    check("clr15_reload", 64'(bus.in_ready), 64'd1);
    $display("[TB] abort at byte 15");

    // Abort mid-ROUND at rnd=17.
    load_block(64'h0, C1, 0, 1'b0);
    push_expected(64'h0);
    repeat (14) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    exp_q.delete();
    check("clr_rnd_busy",      64'(bus.busy),      64'd0);
    check("clr_rnd_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (40) tick();
    check("clr_rnd_quiet", 64'(bus.out_valid), 64'd0);
    $display("[TB] abort at rnd 17");

    // Abort at output byte 3.
    n_accepted = 0;
    load_block(64'h0, C1, 0, 1'b0);
    push_expected(64'h0);
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      tick();
      lat++;
    end
    repeat (3) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    exp_q.delete();
    check("clr_out_accepted",  64'(n_accepted),    64'd3);
    check("clr_out_out_valid", 64'(bus.out_valid), 64'd0);
    check("clr_out_busy",      64'(bus.busy),      64'd0);
    $display("[TB] abort at output byte 3");
    run_cp("vec1_after_abort", 64'h0, C1, 64'h0, 0);

    // Asynchronous reset between edges, mid-ROUND.
    load_block(K2, C2, 0, 1'b0);
    push_expected(K2);
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready",  64'(bus.in_ready),  64'd0);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_out_data",  64'(bus.out_data),  64'd0);
    check("arst_busy",      64'(bus.busy),      64'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    $display("[TB] async reset mid-round");
    run_cp("vec2_after_reset", K2, C2, K2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
